// File: rtl/nisc_mac_cpu.sv
// nisc_mac_cpu: NISC multiply-accumulate core with an external program store.
// The core presents prog_addr and executes the combinational control_word
// {op, chsel, raddr, imm} that comes back in the same cycle.
//
// Ports:
//   clk           rising-edge clock
//   nReset        synchronous active-low reset
//   prog_addr     program counter driven to the external program store
//   control_word  instruction for prog_addr
//   in_data       CHANNELS packed N-bit signed samples, channel c at [c*N +: N]
//   in_valid      per-channel sample valid
//   in_ready      per-channel consume strobe (combinational, 0 in reset)
//   in_flag       per-channel branch condition flags
//   out_data      registered result
//   out_valid     out_data holds an unconsumed result
//   out_ready     downstream accepts out_data
module nisc_mac_cpu #(
  parameter  int N        = 8,
  parameter  int F        = 4,
  parameter  int PSIZE    = 4,
  parameter  int RSIZE    = 2,
  parameter  int CHANNELS = 2,
  localparam int CSEL     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CW       = N + RSIZE + CSEL + 2
) (
  input  logic                  clk,
  input  logic                  nReset,
  output logic [PSIZE-1:0]      prog_addr,
  input  logic [CW-1:0]         control_word,
  input  logic [CHANNELS*N-1:0] in_data,
  input  logic [CHANNELS-1:0]   in_valid,
  output logic [CHANNELS-1:0]   in_ready,
  input  logic [CHANNELS-1:0]   in_flag,
  output logic [N-1:0]          out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int NREG = 2 ** RSIZE;

  typedef enum logic [1:0] {
    OP_MAC    = 2'b00,
    OP_LOAD   = 2'b01,
    OP_BRANCH = 2'b10,
    OP_OUT    = 2'b11
  } op_e;

  // Instruction fields
  logic [N-1:0]     imm;
  logic [RSIZE-1:0] raddr;
  logic [CSEL-1:0]  chsel;
  op_e              op;

  assign imm   = control_word[N-1:0];
  assign raddr = control_word[N +: RSIZE];
  assign chsel = control_word[N+RSIZE +: CSEL];
  assign op    = op_e'(control_word[CW-1 -: 2]);

  // State
  logic [PSIZE-1:0] pc_q, pc_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     rf_q [NREG];

  logic             rf_we;
  logic [N-1:0]     rf_wdata;

  // Channel selection; out-of-range selectors fall back to channel 0
  logic [31:0]      chsel_w;
  logic [CSEL-1:0]  ch_idx;
  logic [N-1:0]     sample;
  logic             sample_valid;
  logic             sample_flag;

  assign chsel_w = 32'(chsel);
  assign ch_idx  = (chsel_w < 32'(CHANNELS)) ? chsel : '0;

  always_comb begin
    sample       = '0;
    sample_valid = 1'b0;
    sample_flag  = 1'b0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (32'(ch_idx) == c) begin
        sample       = in_data[c*N +: N];
        sample_valid = in_valid[c];
        sample_flag  = in_flag[c];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (nReset && (op == OP_MAC)) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        in_ready[c] = (32'(ch_idx) == c);
      end
    end
  end

  // Fixed-point MAC: full product, floor shift by F, widened add, saturate
  logic [N-1:0]          rd;
  logic signed [2*N-1:0] prod;
  logic signed [2*N-1:0] shifted;
  logic signed [2*N:0]   sum;
  logic [N+1:0]          sum_top;
  logic [N-1:0]          mac_res;

  assign rd      = rf_q[raddr];
  assign prod    = $signed(sample) * $signed(imm);
  assign shifted = prod >>> F;
  assign sum     = $signed({shifted[2*N-1], shifted}) + $signed({{(N+1){rd[N-1]}}, rd});
  assign sum_top = sum[2*N:N-1];

  // The sum fits in N bits exactly when all bits from N-1 upward agree.
  always_comb begin
    if ((sum_top == '0) || (sum_top == '1)) begin
      mac_res = sum[N-1:0];
    end else if (sum[2*N]) begin
      mac_res = {1'b1, {(N-1){1'b0}}};
    end else begin
      mac_res = {1'b0, {(N-1){1'b1}}};
    end
  end

  // Sequencing and writeback
  logic out_stall;
  logic out_issue;

  assign out_stall = out_valid_q & ~out_ready;

  always_comb begin
    pc_d       = pc_q;
    rf_we      = 1'b0;
    rf_wdata   = '0;
    out_issue  = 1'b0;
    unique case (op)
      OP_MAC: begin
        if (sample_valid) begin
          rf_we    = 1'b1;
          rf_wdata = mac_res;
          pc_d     = pc_q + PSIZE'(1);
        end
      end
      OP_LOAD: begin
        rf_we    = 1'b1;
        rf_wdata = imm;
        pc_d     = pc_q + PSIZE'(1);
      end
      OP_BRANCH: begin
        if (sample_flag == imm[N-1]) begin
          pc_d = imm[PSIZE-1:0];
        end else begin
          pc_d = pc_q + PSIZE'(1);
        end
      end
      OP_OUT: begin
        if (!out_stall) begin
          out_issue = 1'b1;
          pc_d      = pc_q + PSIZE'(1);
        end
      end
      default: ;
    endcase
  end

  // An issuing OUT reloads the output even when the old value is consumed
  // on the same edge, so back-to-back results keep out_valid high.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (out_issue) begin
      out_data_d  = rd;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      pc_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      if (rf_we) begin
        rf_q[raddr] <= rf_wdata;
      end
    end
  end

  assign prog_addr = pc_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule
